// File: rtl/lcd_pkg.sv
// lcd_pkg: shared states, instruction prefixes, DDRAM address limits and cursor-step helper for the LCD bus receiver.
package lcd_pkg;
    typedef enum logic [1:0] {sPowerUp, sReady, sClear} lcd_state_t;

    localparam logic [7:0] SET_DDRAM  = 8'h80;
    localparam logic [7:0] SET_CGRAM  = 8'h40;
    localparam logic [7:0] FUNC_SET   = 8'h20;
    localparam logic [7:0] SHIFT      = 8'h10;
    localparam logic [7:0] DISP_CTRL  = 8'h08;
    localparam logic [7:0] ENTRY_MODE = 8'h04;
    localparam logic [7:0] HOME       = 8'h02;
    localparam logic [7:0] CLEAR      = 8'h01;

    localparam logic [6:0] LINE0_END  = 7'h27;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE1_END  = 7'h67;
    localparam int         LINE_LEN   = 16;

    localparam logic [7:0] INIT_FUNC  = 8'h38;
    localparam logic [7:0] INIT_DISP  = 8'h0C;
    localparam logic [7:0] INIT_CLEAR = 8'h01;
    localparam logic [7:0] INIT_ENTRY = 8'h06;

    function automatic logic addr_ok(input logic [6:0] a);
        return (a <= LINE0_END) || (a >= LINE1_BASE && a <= LINE1_END);
    endfunction

    // Line 0 wraps into line 1 and line 1 back into line 0; an address
    // parked outside both lines re-enters at the start (up) or end (down).
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
        if (!addr_ok(a))
            return up ? 7'h00 : LINE1_END;
        if (up)
            return a == LINE0_END ? LINE1_BASE : a == LINE1_END ? 7'h00 : a + 7'd1;
        return a == LINE1_BASE ? LINE0_END : a == 7'h00 ? LINE1_END : a - 7'd1;
    endfunction
endpackage

// File: rtl/lcd_bus_sync.sv
// lcd_bus_sync: synchronises E/RS/RW/DB and flags each falling edge of E with the bus value captured alongside it.
// Ports: clk, reset (async, active-high); E, RS, RW, DB bus inputs;
//        txn_valid one-cycle flag, txn_rs, txn_rw, txn_db captured bus fields.
module lcd_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       E,
    input  logic       RS,
    input  logic       RW,
    input  logic [7:0] DB,
    output logic       txn_valid,
    output logic       txn_rs,
    output logic       txn_rw,
    output logic [7:0] txn_db
);
    logic [SYNC_STAGES-1:0][10:0] sr;
    logic                         e_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr     <= '0;
            e_prev <= 1'b0;
        end else begin
            sr     <= {sr[SYNC_STAGES-2:0], {E, RS, RW, DB}};
            e_prev <= sr[SYNC_STAGES-1][10];
        end
    end

    // RS/RW/DB travel through the same stages as E, so the capture is coherent.
    assign txn_valid = e_prev & ~sr[SYNC_STAGES-1][10];
    assign txn_rs    = sr[SYNC_STAGES-1][9];
    assign txn_rw    = sr[SYNC_STAGES-1][8];
    assign txn_db    = sr[SYNC_STAGES-1][7:0];
endmodule

// File: rtl/lcd_receiver.sv
// lcd_receiver: HD44780-style bus responder keeping a 2x16 character mirror plus cursor and display-control state.
// Ports: clk, reset (async, active-high); E, RS, RW, DB bus; clr_err clears err;
//        chars display buffer, cursor_addr, display_on/cursor_on/blink_on, inc_mode,
//        configured, busy, err (sticky), wr_strobe (pulse per stored byte).
module lcd_receiver
    import lcd_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CLEAR_FILL  = 8'h20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E,
    input  logic             RS,
    input  logic             RW,
    input  logic [7:0]       DB,
    input  logic             clr_err,
    output logic [0:31][7:0] chars,
    output logic [6:0]       cursor_addr,
    output logic             display_on,
    output logic             cursor_on,
    output logic             blink_on,
    output logic             inc_mode,
    output logic             configured,
    output logic             busy,
    output logic             err,
    output logic             wr_strobe
);
    lcd_state_t       state, state_n;
    logic             txn_valid, txn_rs, txn_rw;
    logic [7:0]       txn_db;
    logic [4:0]       cnt, cnt_n;
    logic [0:31][7:0] chars_n;
    logic [6:0]       cur_n;
    logic             disp_n, curs_n, blink_n, inc_n, cfg_n, err_set, wr_n;

    lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .E        (E),
        .RS       (RS),
        .RW       (RW),
        .DB       (DB),
        .txn_valid(txn_valid),
        .txn_rs   (txn_rs),
        .txn_rw   (txn_rw),
        .txn_db   (txn_db)
    );

    assign busy = (state == sClear);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= sPowerUp;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        chars_n = chars;
        cur_n   = cursor_addr;
        disp_n  = display_on;
        curs_n  = cursor_on;
        blink_n = blink_on;
        inc_n   = inc_mode;
        cfg_n   = configured;
        cnt_n   = cnt;
        err_set = 1'b0;
        wr_n    = 1'b0;
        unique case (state)
            sPowerUp: begin
                if (txn_valid) begin
                    if (!txn_rw && !txn_rs && txn_db[7:4] == 4'b0011) begin
                        cfg_n   = 1'b1;
                        state_n = sReady;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            sReady: begin
                if (txn_valid) begin
                    if (txn_rw) begin
                        err_set = 1'b1;
                    end else if (txn_rs) begin
                        if (cursor_addr[6:4] == 3'b000) begin
                            chars_n[{1'b0, cursor_addr[3:0]}] = txn_db;
                            wr_n = 1'b1;
                        end else if (cursor_addr[6:4] == 3'b100) begin
                            chars_n[{1'b1, cursor_addr[3:0]}] = txn_db;
                            wr_n = 1'b1;
                        end
                        cur_n = step_addr(cursor_addr, inc_mode);
                    end else if (txn_db[7]) begin
                        cur_n   = txn_db[6:0];
                        err_set = !addr_ok(txn_db[6:0]);
                    end else if (txn_db[6]) begin
                        err_set = 1'b1;
                    end else if (txn_db[5]) begin
                        err_set = !txn_db[4];
                    end else if (txn_db[4]) begin
                        cur_n = txn_db[3] ? cursor_addr : step_addr(cursor_addr, txn_db[2]);
                    end else if (txn_db[3]) begin
                        {disp_n, curs_n, blink_n} = txn_db[2:0];
                    end else if (txn_db[2]) begin
                        inc_n = txn_db[1];
                    end else if (txn_db[1]) begin
                        cur_n = 7'h00;
                    end else if (txn_db[0]) begin
                        state_n = sClear;
                        cnt_n   = 5'd0;
                    end
                end
            end
            sClear: begin
                chars_n[cnt] = CLEAR_FILL;
                cnt_n        = cnt + 5'd1;
                err_set      = txn_valid;
                if (cnt == 5'd31) begin
                    state_n = sReady;
                    cur_n   = 7'h00;
                    inc_n   = 1'b1;
                end
            end
            default: state_n = sPowerUp;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chars       <= {32{CLEAR_FILL}};
            cursor_addr <= 7'h00;
            display_on  <= 1'b0;
            cursor_on   <= 1'b0;
            blink_on    <= 1'b0;
            inc_mode    <= 1'b1;
            configured  <= 1'b0;
            err         <= 1'b0;
            wr_strobe   <= 1'b0;
            cnt         <= 5'd0;
        end else begin
            chars       <= chars_n;
            cursor_addr <= cur_n;
            display_on  <= disp_n;
            cursor_on   <= curs_n;
            blink_on    <= blink_n;
            inc_mode    <= inc_n;
            configured  <= cfg_n;
            err         <= err_set | (err & ~clr_err);
            wr_strobe   <= wr_n;
            cnt         <= cnt_n;
        end
    end
endmodule

// File: tb/tb_lcd_receiver.sv
// tb_lcd_receiver: directed bus transactions with a strobe scoreboard and direct state checks.
module tb_lcd_receiver;
    logic             clk = 1'b0;
    logic             reset, E, RS, RW, clr_err;
    logic [7:0]       DB;
    logic [0:31][7:0] chars;
    logic [6:0]       cursor_addr;
    logic             display_on, cursor_on, blink_on, inc_mode, configured, busy, err, wr_strobe;

    typedef struct {
        int         idx;
        logic [7:0] b;
        logic [6:0] cur;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    logic [7:0] exp_chars[32];
    int         vectors = 0;
    int         miscompares = 0;
    int         busy_cycles, wt;
    string      l0 = "HELLO, WORLD! 12";
    string      l1 = "LCD RECEIVER OK!";

    always #10 clk = ~clk;

    lcd_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .E          (E),
        .RS         (RS),
        .RW         (RW),
        .DB         (DB),
        .clr_err    (clr_err),
        .chars      (chars),
        .cursor_addr(cursor_addr),
        .display_on (display_on),
        .cursor_on  (cursor_on),
        .blink_on   (blink_on),
        .inc_mode   (inc_mode),
        .configured (configured),
        .busy       (busy),
        .err        (err),
        .wr_strobe  (wr_strobe)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_chars(input string name);
        int bad = -1;
        vectors++;
        for (int i = 31; i >= 0; i--)
            if (chars[i] !== exp_chars[i]) bad = i;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s: chars[%0d] got %0h expected %0h", name, bad, chars[bad], exp_chars[bad]);
        end
    endtask

    task automatic pulse(input logic rs, input logic rw, input logic [7:0] db);
        @(negedge clk);
        RS = rs;
        RW = rw;
        DB = db;
        E  = 1'b1;
        repeat (2) @(negedge clk);
        E = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send(input logic rs, input logic rw, input logic [7:0] db);
        pulse(rs, rw, db);
        repeat (4) @(negedge clk);
    endtask

    task automatic instr(input logic [7:0] db);
        send(1'b0, 1'b0, db);
    endtask

    task automatic data_store(input logic [7:0] b, input int idx, input logic [6:0] cur);
        exp_t e;
        e.idx = idx;
        e.b   = b;
        e.cur = cur;
        q.push_back(e);
        exp_chars[idx] = b;
        send(1'b1, 1'b0, b);
    endtask

    task automatic do_clr_err();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        chk("clr_err", err, 1'b0);
    endtask

    task automatic chk_reset_state(input string name);
        chk_chars(name);
        chk({name, "_cursor"}, cursor_addr, 7'h00);
        chk({name, "_dcb"}, {display_on, cursor_on, blink_on}, 3'b000);
        chk({name, "_inc"}, inc_mode, 1'b1);
        chk({name, "_flags"}, {configured, busy, err, wr_strobe}, 4'b0000);
    endtask

    always @(negedge clk) begin
        if (wr_strobe) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: got strobe at cursor %0h expected none", cursor_addr);
            end else begin
                mon_e = q.pop_front();
                chk("strobe_char", chars[mon_e.idx], mon_e.b);
                chk("strobe_cursor", cursor_addr, mon_e.cur);
            end
        end
    end

    initial begin
        reset = 1'b1;
        E = 1'b0;
        RS = 1'b0;
        RW = 1'b0;
        DB = 8'h00;
        clr_err = 1'b0;
        for (int i = 0; i < 32; i++) exp_chars[i] = 8'h20;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_state("reset");

        send(1'b1, 1'b0, 8'h41);
        chk("pre_config_err", err, 1'b1);
        chk("pre_config_cfg", configured, 1'b0);
        chk_chars("pre_config_chars");
        do_clr_err();

        instr(8'h38);
        instr(8'h0F);
        instr(8'h0E);
        instr(8'h06);
        chk("init_cfg", configured, 1'b1);
        chk("init_dcb", {display_on, cursor_on, blink_on}, 3'b110);
        chk("init_inc_err", {inc_mode, err}, 2'b10);

        instr(8'h80);
        data_store(8'h41, 0, 7'h01);
        data_store(8'h42, 1, 7'h02);
        chk("write_cursor", cursor_addr, 7'h02);

        instr(8'hCF);
        data_store(8'h5A, 31, 7'h50);
        send(1'b1, 1'b0, 8'h51);
        chk("line1_nostore_cursor", cursor_addr, 7'h51);
        instr(8'hE7);
        send(1'b1, 1'b0, 8'h52);
        chk("wrap_67_cursor", cursor_addr, 7'h00);
        instr(8'hA7);
        send(1'b1, 1'b0, 8'h53);
        chk("wrap_27_cursor", cursor_addr, 7'h40);
        instr(8'h10);
        chk("shift_left_cursor", cursor_addr, 7'h27);
        instr(8'h14);
        chk("shift_right_cursor", cursor_addr, 7'h40);
        chk("wrap_err", err, 1'b0);
        chk_chars("after_wrap_chars");

        instr(8'hB0);
        chk("bad_addr_err", err, 1'b1);
        chk("bad_addr_cursor", cursor_addr, 7'h30);
        send(1'b1, 1'b0, 8'h54);
        chk("bad_addr_step", cursor_addr, 7'h00);
        do_clr_err();

        instr(8'h04);
        chk("entry_dec", inc_mode, 1'b0);
        instr(8'h80);
        data_store(8'h33, 0, 7'h67);
        send(1'b1, 1'b0, 8'h34);
        chk("dec_cursor", cursor_addr, 7'h66);
        instr(8'h02);
        chk("home_cursor", cursor_addr, 7'h00);

        instr(8'h28);
        chk("func_dl0_err", err, 1'b1);
        do_clr_err();
        instr(8'h45);
        chk("cgram_err", err, 1'b1);
        do_clr_err();

        instr(8'h85);
        send(1'b1, 1'b1, 8'h99);
        chk("rw_err", err, 1'b1);
        chk("rw_cursor", cursor_addr, 7'h05);
        chk_chars("rw_chars");
        do_clr_err();

        fork
            begin
                pulse(1'b0, 1'b0, 8'h01);
                repeat (6) @(negedge clk);
                pulse(1'b1, 1'b0, 8'h77);
            end
            begin
                busy_cycles = 0;
                wt = 0;
                while (!busy && wt < 40) begin
                    @(negedge clk);
                    wt++;
                end
                while (busy && busy_cycles < 100) begin
                    @(negedge clk);
                    busy_cycles++;
                end
            end
        join
        for (int i = 0; i < 32; i++) exp_chars[i] = 8'h20;
        repeat (4) @(negedge clk);
        chk("clear_busy_cycles", busy_cycles, 32);
        chk_chars("clear_chars");
        chk("clear_cursor", cursor_addr, 7'h00);
        chk("clear_inc", inc_mode, 1'b1);
        chk("clear_dcb", {display_on, cursor_on, blink_on}, 3'b110);
        chk("clear_drop_err", err, 1'b1);
        do_clr_err();

        instr(8'h80);
        for (int i = 0; i < 16; i++) data_store(l0[i], i, 7'(i + 1));
        instr(8'hC0);
        for (int i = 0; i < 16; i++) data_store(l1[i], 16 + i, 7'(8'h41 + i));
        chk_chars("loopback_chars");
        chk("loopback_err", err, 1'b0);

        pulse(1'b0, 1'b0, 8'h01);
        wt = 0;
        while (!busy && wt < 40) begin
            @(negedge clk);
            wt++;
        end
        chk("midclear_busy", busy, 1'b1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) exp_chars[i] = 8'h20;
        chk_reset_state("midclear_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_reset_busy", busy, 1'b0);
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lcd_receiver.md
Name: lcd_receiver

Overview:
Responder end of the parallel HD44780-style LCD bus (E/RS/RW/DB) driven by the team's LCD driver. Decodes instruction and data transactions on the falling edge of E and keeps a 2x16 character display model in registers, plus cursor and display-control state. Used as the on-chip display mirror for the VGA text overlay and as the scoreboard model in driver testbenches.

Parameters:
SYNC_STAGES, 2, flops in the E/RS/RW/DB input synchroniser (minimum 2).
CLEAR_FILL, 8'h20, byte written to every cell by the Clear Display instruction and by reset.

Ports:
clk  in  1  master 50 MHz clock
reset  in  1  asynchronous, active-high reset
E  in  1  bus enable; a transaction is taken on its falling edge
RS  in  1  0 = instruction, 1 = data
RW  in  1  0 = write; 1 = read (unsupported)
DB  in  8  bus data
clr_err  in  1  single-cycle pulse that clears err
chars  out  [0:31][7:0]  display buffer; 0-15 = line 0, 16-31 = line 1
cursor_addr  out  7  current DDRAM address
display_on, cursor_on, blink_on  out  1 each  D/C/B bits from Display Control
inc_mode  out  1  1 = cursor increments after a data write
configured  out  1  a valid 8-bit Function Set has been accepted
busy  out  1  high while a Clear is in progress
err  out  1  sticky protocol-error flag
wr_strobe  out  1  one-cycle pulse when a data byte is stored in chars

Behaviour:
- One clock. Reset is asynchronous and active-high. Reset values: chars all CLEAR_FILL, cursor_addr 0, display_on/cursor_on/blink_on 0, inc_mode 1, configured 0, busy 0, err 0, wr_strobe 0, state sPowerUp. Reset during a Clear aborts it immediately.
- E, RS, RW and DB each pass through the SYNC_STAGES synchroniser. A falling edge (last stage 0, previous 1) captures RS/RW/DB from the same stage. An E pulse of 1 cycle high and 1 cycle low is detected.
- Latency: the resulting update on the outputs is registered SYNC_STAGES+1 rising edges after the first edge that samples E=0.
- States: sPowerUp, sReady, sClear.
- sPowerUp: only Function Set with DL=1 (DB[7:4]=0011) is accepted; it sets configured=1 and moves to sReady. Any other transaction is dropped and sets err.
- sReady instruction decode (RS=0) uses the highest set bit of DB:
  - 1aaaaaaa: cursor_addr = DB[6:0].
  - 01xxxxxx: CGRAM access, unsupported; sets err.
  - 001xxxxx: Function Set. With DL=1 it has no effect; with DL=0 it sets err.
  - 0001 S/C R/L xx: with S/C=0, the cursor moves right (R/L=1) or left by one using the wrap rule. With S/C=1 the display shift is ignored.
  - 00001DCB: loads display_on, cursor_on, blink_on.
  - 000001 I/D S: loads inc_mode = I/D. S is ignored.
  - 0000001x: Return Home sets cursor_addr = 0.
  - 00000001: enters sClear.
  - 0x00: ignored.
- Data (RS=1) in sReady:
  - Addresses 0x00-0x0F store to chars[addr]. Addresses 0x40-0x4F store to chars[16+addr-0x40]. A store pulses wr_strobe.
  - Other addresses are valid cursor positions but are not stored.
  - Afterwards the cursor steps +1 if inc_mode, else -1.
- Cursor wrap rule: the address space is 0x00-0x27 and 0x40-0x67. Incrementing 0x27 gives 0x40 and 0x67 gives 0x00; decrementing reverses this. Set DDRAM to an address outside the space sets err and loads the address; the next step wraps to 0x00 (increment) or 0x67 (decrement).
- sClear: busy=1 for exactly 32 cycles, writing CLEAR_FILL to index 0..31, one per cycle. On exit cursor_addr=0, inc_mode=1, and the state returns to sReady. Display bits are unchanged.
- Any transaction detected while busy=1, including in the final busy cycle, is dropped and sets err.
- RW=1 transactions are dropped in every state and set err.
- err stays set until clr_err. If clr_err and a new error occur in the same cycle, the set wins.

Decomposition:
- Package lcd_pkg holds: the state enum; instruction prefix constants (SET_DDRAM, SET_CGRAM, FUNC_SET, SHIFT, DISP_CTRL, ENTRY_MODE, HOME, CLEAR); address constants LINE0_END=7'h27, LINE1_BASE=7'h40, LINE1_END=7'h67, LINE_LEN=16; and the init byte constants shared with the driver.
- One sub-module, lcd_bus_sync: the synchroniser plus falling-edge capture. It outputs txn_valid, txn_rs, txn_rw, txn_db.

Test Plan:
- Init: reset, then bytes 0x38, 0x0F, 0x0E, 0x06 (RS=0) -> configured=1, display_on=1, cursor_on=1, blink_on=0, inc_mode=1, err=0.
- Write: 0x80, then data 0x41, 0x42 -> chars[0]=0x41, chars[1]=0x42, cursor_addr=0x02, two wr_strobe pulses.
- Line 1 and wrap: 0xCF, data 0x5A -> chars[31]=0x5A, cursor 0x50. Data 0x51 -> nothing stored, cursor 0x51. Then 0xE7 plus data -> cursor 0x00.
- Clear: 0x01 -> busy high exactly 32 cycles, all chars 0x20, cursor_addr 0. Data issued mid-clear is dropped and err=1. clr_err -> err=0.
- Protocol errors: data before Function Set -> ignored, err=1. RW=1 write in sReady -> err=1, no state change.
- Reset mid-clear, plus loopback: assert reset at clear cycle 10 -> all outputs at reset values that cycle. Connect the LCD driver fed a 32-char string -> chars equals the string after one full refresh pass.
